// File: rtl/apb_timer_slave.sv
// apb_timer_slave: APB slave exposing a down-counting timer with auto-reload,
// a sticky expiry flag and an interrupt line. Every transfer is stretched by
// WAIT_STATES access cycles before pready is raised.
//
// Ports:
//   pclk, presetn            clock, synchronous active-low reset
//   psel, penable, pwrite    APB control
//   paddr, pwdata            APB byte address / write data
//   prdata, pready, pslverr  APB response (prdata/pslverr zero unless pready)
//   irq                      INTSTAT[0] & CTRL[2]
//
// Register map (offset = paddr[7:0]):
//   0x00 CTRL    RW  [0] en, [1] reload, [2] irq_en
//   0x08 LOAD    RW  [CNT_WIDTH-1:0]; a write also loads VALUE
//   0x10 VALUE   RO  current count
//   0x18 INTSTAT W1C [0] expired
module apb_timer_slave #(
  parameter int PADDR_WIDTH = 30,
  parameter int DATA_WIDTH  = 64,
  parameter int CNT_WIDTH   = 32,
  parameter int WAIT_STATES = 1
) (
  input  logic                   pclk,
  input  logic                   presetn,
  input  logic                   psel,
  input  logic                   penable,
  input  logic [PADDR_WIDTH-1:0] paddr,
  input  logic                   pwrite,
  input  logic [DATA_WIDTH-1:0]  pwdata,
  output logic [DATA_WIDTH-1:0]  prdata,
  output logic                   pready,
  output logic                   pslverr,
  output logic                   irq
);

  localparam logic [7:0] OFF_CTRL    = 8'h00;
  localparam logic [7:0] OFF_LOAD    = 8'h08;
  localparam logic [7:0] OFF_VALUE   = 8'h10;
  localparam logic [7:0] OFF_INTSTAT = 8'h18;
  localparam logic [3:0] WAIT_LOAD   = 4'(WAIT_STATES);

  logic [2:0]            ctrl;
  logic [CNT_WIDTH-1:0]  load_q;
  logic [CNT_WIDTH-1:0]  value_q;
  logic                  intstat;
  logic [3:0]            wait_cnt;
  // Set by a setup phase, cleared on completion, abort or reset. Keeps an
  // access phase that was not preceded by a setup (e.g. one that straddled a
  // reset) from completing on a zeroed wait counter.
  logic                  armed;

  logic [7:0]            offset;
  logic                  addr_err;
  logic                  acc_err;
  logic                  wr_ok;
  logic                  expire;
  logic [DATA_WIDTH-1:0] rd_mux;
  logic                  unused_bits;

  assign offset      = paddr[7:0];
  assign unused_bits = ^{paddr[PADDR_WIDTH-1:8], pwdata};

  always_comb begin
    addr_err = 1'b0;
    rd_mux   = '0;
    case (offset)
      OFF_CTRL:    rd_mux = DATA_WIDTH'(ctrl);
      OFF_LOAD:    rd_mux = DATA_WIDTH'(load_q);
      OFF_VALUE:   rd_mux = DATA_WIDTH'(value_q);
      OFF_INTSTAT: rd_mux = DATA_WIDTH'(intstat);
      default:     addr_err = 1'b1;
    endcase
  end

  assign acc_err = addr_err | (pwrite & (offset == OFF_VALUE));
  assign pready  = psel & penable & armed & (wait_cnt == 4'd0);
  assign pslverr = pready & acc_err;
  assign prdata  = (pready & ~pwrite & ~acc_err) ? rd_mux : '0;
  assign wr_ok   = pready & pwrite & ~acc_err;
  assign expire  = ctrl[0] & (value_q == '0);
  assign irq     = intstat & ctrl[2];

  always_ff @(posedge pclk) begin
    if (!presetn) begin
      ctrl     <= '0;
      load_q   <= '0;
      value_q  <= '0;
      intstat  <= 1'b0;
      wait_cnt <= '0;
      armed    <= 1'b0;
    end else begin
      // Handshake: setup loads the wait budget, access burns it down.
      if (psel && !penable) begin
        wait_cnt <= WAIT_LOAD;
        armed    <= 1'b1;
      end else if (psel && penable) begin
        if (wait_cnt != 4'd0) wait_cnt <= wait_cnt - 4'd1;
        if (pready) armed <= 1'b0;
      end else begin
        armed <= 1'b0;
      end

      // Timer. Register writes below are placed later so they override.
      if (ctrl[0]) begin
        if (value_q != '0)  value_q <= value_q - CNT_WIDTH'(1);
        else if (ctrl[1])   value_q <= load_q;
        else                ctrl[0] <= 1'b0;
      end

      // Expiry beats a simultaneous write-1-to-clear.
      if (expire)
        intstat <= 1'b1;
      else if (wr_ok && (offset == OFF_INTSTAT) && pwdata[0])
        intstat <= 1'b0;

      if (wr_ok) begin
        case (offset)
          OFF_CTRL: ctrl <= pwdata[2:0];
          OFF_LOAD: begin
            load_q  <= pwdata[CNT_WIDTH-1:0];
            value_q <= pwdata[CNT_WIDTH-1:0];
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_apb_timer_slave.sv
module tb_apb_timer_slave;

  logic        pclk = 1'b0;
  logic        presetn;
  logic        psel;
  logic        penable;
  logic [29:0] paddr;
  logic        pwrite;
  logic [63:0] pwdata;
  logic        tgt;  // 0: WAIT_STATES=1 instance, 1: WAIT_STATES=0 instance

  logic        psel1, psel0;
  logic [63:0] prdata1, prdata0, prdata_m;
  logic        pready1, pready0, pready_m;
  logic        pslverr1, pslverr0, pslverr_m;
  logic        irq1, irq0;

  int checks = 0;
  int errors = 0;

  always #5 pclk = ~pclk;

  assign psel1     = psel & ~tgt;
  assign psel0     = psel & tgt;
  assign prdata_m  = tgt ? prdata0  : prdata1;
  assign pready_m  = tgt ? pready0  : pready1;
  assign pslverr_m = tgt ? pslverr0 : pslverr1;

  apb_timer_slave #(.PADDR_WIDTH(30), .DATA_WIDTH(64), .CNT_WIDTH(32), .WAIT_STATES(1)) dut_ws1 (
    .pclk(pclk), .presetn(presetn), .psel(psel1), .penable(penable), .paddr(paddr),
    .pwrite(pwrite), .pwdata(pwdata), .prdata(prdata1), .pready(pready1),
    .pslverr(pslverr1), .irq(irq1));

  apb_timer_slave #(.PADDR_WIDTH(30), .DATA_WIDTH(64), .CNT_WIDTH(32), .WAIT_STATES(0)) dut_ws0 (
    .pclk(pclk), .presetn(presetn), .psel(psel0), .penable(penable), .paddr(paddr),
    .pwrite(pwrite), .pwdata(pwdata), .prdata(prdata0), .pready(pready0),
    .pslverr(pslverr0), .irq(irq0));

  // Called at posedge+1; returns at posedge+1 just after the completing edge,
  // with psel dropped (a following call re-asserts it with no idle cycle).
  task automatic apb(input logic wr, input logic [29:0] a, input logic [63:0] d,
                     output logic [63:0] rd, output logic err, output int cyc);
    int  n;
    bit  done;
    rd = '0; err = 1'b0; cyc = 0; done = 0;
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d;
    @(posedge pclk); #1;
    penable = 1'b1;
    n = 2;
    while (!done) begin
      @(negedge pclk);
      if (pready_m) begin
        rd = prdata_m; err = pslverr_m; cyc = n; done = 1;
      end else if (n >= 20) begin
        checks++; errors++;
        $display("FAIL apb_timeout addr=%0h: no pready after %0d cycles", a, n);
        done = 1;
      end
      @(posedge pclk); #1;
      n++;
    end
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic test_reset;
    logic [63:0] rd; logic err; int cyc;
    tgt = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0;
    presetn = 1'b0;
    repeat (2) @(posedge pclk);
    #1;
    checks++;
    if ({pready1, pslverr1, irq1, prdata1} !== 67'd0) begin
      errors++; $display("FAIL reset_outputs: got %0h want 0", {pready1, pslverr1, irq1, prdata1});
    end
    presetn = 1'b1;
    @(posedge pclk); #1;
    for (int i = 0; i < 4; i++) begin
      apb(1'b0, 30'(i * 8), 64'd0, rd, err, cyc);
      checks++;
      if (rd !== 64'd0 || err !== 1'b0 || cyc != 3) begin
        errors++;
        $display("FAIL reset_read_%0d: got data=%0h err=%b cycles=%0d want 0/0/3", i, rd, err, cyc);
      end
    end
  endtask

  task automatic test_oneshot;
    logic [63:0] rd; logic err; int cyc;
    logic [63:0] exp_rd [5];
    logic [29:0] addr_s [5];
    // CTRL commit edge = E0; VALUE after Ek = 5-k, expiry at E6.
    // Read n completes in the cycle after edge E(3n+2).
    addr_s = '{30'h10, 30'h18, 30'h18, 30'h10, 30'h00};
    exp_rd = '{64'd3,  64'd0,  64'd1,  64'd0,  64'd0};
    apb(1'b1, 30'h08, 64'd5, rd, err, cyc);
    apb(1'b1, 30'h00, 64'd1, rd, err, cyc);
    for (int i = 0; i < 5; i++) begin
      apb(1'b0, addr_s[i], 64'd0, rd, err, cyc);
      checks++;
      if (rd !== exp_rd[i] || err !== 1'b0) begin
        errors++;
        $display("FAIL oneshot_read_%0d @%0h: got %0h err=%b want %0h err=0", i, addr_s[i], rd, err, exp_rd[i]);
      end
    end
    checks++;
    if (irq1 !== 1'b0) begin errors++; $display("FAIL oneshot_irq: got %b want 0", irq1); end
  endtask

  // CTRL=7 commit edge = Q0; VALUE after Qk = 3-(k mod 4), expiry at Q4, Q8, ...
  task automatic test_reload;
    logic [63:0] rd; logic err; int cyc;
    apb(1'b1, 30'h18, 64'd1, rd, err, cyc);
    apb(1'b1, 30'h08, 64'd3, rd, err, cyc);
    apb(1'b1, 30'h00, 64'd7, rd, err, cyc);
    apb(1'b0, 30'h10, 64'd0, rd, err, cyc);  // completes after Q2
    checks++;
    if (rd !== 64'd1) begin errors++; $display("FAIL reload_value: got %0h want 1", rd); end
    @(negedge pclk);  // Q3..Q4
    checks++;
    if (irq1 !== 1'b0) begin errors++; $display("FAIL reload_irq_pre: got %b want 0", irq1); end
    @(negedge pclk);  // Q4..Q5
    checks++;
    if (irq1 !== 1'b1) begin errors++; $display("FAIL reload_irq_first: got %b want 1", irq1); end
    @(posedge pclk); #1;
    @(posedge pclk); #1;                      // Q6+1
    apb(1'b1, 30'h18, 64'd1, rd, err, cyc);   // commits at Q9
    @(negedge pclk);  // Q9..Q10
    checks++;
    if (irq1 !== 1'b0) begin errors++; $display("FAIL w1c_irq_drop: got %b want 0", irq1); end
    repeat (2) @(negedge pclk);  // Q11..Q12
    checks++;
    if (irq1 !== 1'b0) begin errors++; $display("FAIL w1c_irq_hold_low: got %b want 0", irq1); end
    @(negedge pclk);  // Q12..Q13
    checks++;
    if (irq1 !== 1'b1) begin errors++; $display("FAIL reload_irq_second: got %b want 1", irq1); end
    @(posedge pclk); #1;                      // Q13+1
    apb(1'b1, 30'h18, 64'd1, rd, err, cyc);   // commits at Q16, same edge as expiry
    @(negedge pclk);
    checks++;
    if (irq1 !== 1'b1) begin errors++; $display("FAIL collision_irq: got %b want 1", irq1); end
    @(posedge pclk); #1;
    apb(1'b0, 30'h18, 64'd0, rd, err, cyc);
    checks++;
    if (rd !== 64'd1) begin errors++; $display("FAIL collision_intstat: got %0h want 1", rd); end
  endtask

  task automatic test_errors;
    logic [63:0] rd; logic err; int cyc;
    apb(1'b1, 30'h00, 64'd0, rd, err, cyc);
    apb(1'b1, 30'h08, 64'd9, rd, err, cyc);
    apb(1'b1, 30'h10, 64'h55, rd, err, cyc);
    checks++;
    if (err !== 1'b1) begin errors++; $display("FAIL err_write_value: pslverr got %b want 1", err); end
    apb(1'b0, 30'h10, 64'd0, rd, err, cyc);
    checks++;
    if (rd !== 64'd9 || err !== 1'b0) begin
      errors++; $display("FAIL value_untouched: got %0h err=%b want 9 err=0", rd, err);
    end
    apb(1'b0, 30'h20, 64'd0, rd, err, cyc);
    checks++;
    if (rd !== 64'd0 || err !== 1'b1) begin
      errors++; $display("FAIL err_read_0x20: got %0h err=%b want 0 err=1", rd, err);
    end
    apb(1'b0, 30'h04, 64'd0, rd, err, cyc);
    checks++;
    if (rd !== 64'd0 || err !== 1'b1) begin
      errors++; $display("FAIL err_read_0x04: got %0h err=%b want 0 err=1", rd, err);
    end
    apb(1'b0, 30'h108, 64'd0, rd, err, cyc);
    checks++;
    if (rd !== 64'd9 || err !== 1'b0) begin
      errors++; $display("FAIL upper_addr_ignored: got %0h err=%b want 9 err=0", rd, err);
    end
  endtask

  task automatic test_back_to_back;
    logic [63:0] rd; logic err; int cyc;
    tgt = 1'b1;
    apb(1'b1, 30'h08, 64'hFFFF_FFFF_DEAD_BEEF, rd, err, cyc);
    checks++;
    if (cyc != 2 || err !== 1'b0) begin
      errors++; $display("FAIL b2b_write: cycles=%0d err=%b want 2/0", cyc, err);
    end
    apb(1'b0, 30'h08, 64'd0, rd, err, cyc);
    checks++;
    if (cyc != 2 || rd !== 64'h0000_0000_DEAD_BEEF) begin
      errors++; $display("FAIL b2b_read_load: cycles=%0d data=%0h want 2/deadbeef", cyc, rd);
    end
    apb(1'b0, 30'h10, 64'd0, rd, err, cyc);
    checks++;
    if (rd !== 64'h0000_0000_DEAD_BEEF) begin
      errors++; $display("FAIL b2b_read_value: got %0h want deadbeef", rd);
    end
    tgt = 1'b0;
  endtask

  task automatic test_reset_in_wait;
    logic [63:0] rd; logic err; int cyc;
    apb(1'b1, 30'h08, 64'd7, rd, err, cyc);
    apb(1'b1, 30'h00, 64'd7, rd, err, cyc);
    psel = 1'b1; penable = 1'b0; paddr = 30'h10; pwrite = 1'b0;
    @(posedge pclk); #1;
    penable = 1'b1;
    @(negedge pclk);
    checks++;
    if (pready1 !== 1'b0) begin errors++; $display("FAIL rst_wait_state: pready got %b want 0", pready1); end
    @(posedge pclk); #1;
    presetn = 1'b0;
    @(posedge pclk); #1;
    presetn = 1'b1;
    @(negedge pclk);
    checks++;
    if (pready1 !== 1'b0 || irq1 !== 1'b0) begin
      errors++; $display("FAIL rst_in_access: pready=%b irq=%b want 0/0", pready1, irq1);
    end
    @(posedge pclk); #1;
    for (int i = 0; i < 4; i++) begin
      apb(1'b0, 30'(i * 8), 64'd0, rd, err, cyc);
      checks++;
      if (rd !== 64'd0 || err !== 1'b0) begin
        errors++; $display("FAIL rst_regs_%0d: got %0h err=%b want 0/0", i, rd, err);
      end
    end
  endtask

  initial begin
    test_reset();
    test_oneshot();
    test_reload();
    test_errors();
    test_back_to_back();
    test_reset_in_wait();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/apb_timer_slave.md
Name: apb_timer_slave

Overview:
- 64-bit APB slave peripheral hanging off one psel line of the AHB-to-APB bridge; consumes the bridge's APB requests and returns prdata, pready and pslverr.
- Implements a down-counting timer with auto-reload, a sticky interrupt status flag and an interrupt output.
- A programmable number of wait states is inserted on every access, so the bridge's pready and pslverr paths are exercised.

Parameters:
- PADDR_WIDTH, 30, APB address width; matches the bridge.
- DATA_WIDTH, 64, APB data width; matches the bridge.
- CNT_WIDTH, 32, timer counter width; must be less than or equal to DATA_WIDTH.
- WAIT_STATES, 1, number of access-phase cycles with pready low before completion; range 0..15.

Ports:
- pclk  in  1  clock; the bridge's hclk.
- presetn  in  1  synchronous active-low reset.
- psel  in  1  select; one bit of the bridge psel bus.
- penable  in  1  APB access phase.
- paddr  in  PADDR_WIDTH  byte address.
- pwrite  in  1  1 = write.
- pwdata  in  DATA_WIDTH  write data.
- prdata  out  DATA_WIDTH  read data.
- pready  out  1  transfer complete.
- pslverr  out  1  transfer error.
- irq  out  1  interrupt = INTSTAT[0] & CTRL[2].

Behaviour:
- Reset:
  - Sampled on the pclk rising edge when presetn=0.
  - prdata=0, pready=0, pslverr=0, irq=0.
  - CTRL=0, LOAD=0, VALUE=0, INTSTAT=0, wait counter=0.
- Register map: offset = paddr[7:0]; paddr[PADDR_WIDTH-1:8] is ignored.
  - 0x00 CTRL, RW: [0] en, [1] reload, [2] irq_en; other bits read 0.
  - 0x08 LOAD, RW: [CNT_WIDTH-1:0]. A write also copies the value into VALUE in the same cycle.
  - 0x10 VALUE, RO: current count.
  - 0x18 INTSTAT: [0] expired; write-1-to-clear.
  - Upper unused bits read 0.
- Errors:
  - Triggers: any offset not in the map, any paddr[2:0]!=0, or a write to VALUE.
  - Response: pslverr=1 in the completing cycle, no register change, prdata=0.
- APB handshake:
  - Setup cycle (psel=1, penable=0): wait counter loads WAIT_STATES.
  - Access cycles (psel=1, penable=1): wait counter decrements while non-zero.
  - pready = psel & penable & (wait counter==0). It is combinational from the counter, so WAIT_STATES=0 gives zero-wait completion.
  - Write commits on the pclk edge ending the cycle where pready=1.
  - prdata and pslverr are valid only while pready=1; otherwise both are 0.
  - Total latency per transfer: setup + WAIT_STATES + 1 cycles.
  - psel dropping mid-access (protocol violation): abort, no commit, counter is reloaded by the next setup.
  - Back-to-back transfers (a setup immediately after completion) are supported.
- Timer, evaluated every cycle while en=1:
  - VALUE!=0: VALUE decrements by 1.
  - VALUE==0: INTSTAT[0] is set. If reload=1, VALUE<=LOAD. If reload=0, en is cleared and VALUE stays 0.
  - With LOAD=0 and reload=1, INTSTAT is set every cycle.
- Simultaneous events:
  - Expiry and a W1C clear in the same cycle: set wins.
  - A LOAD write in the same cycle as a decrement: the LOAD write wins.
  - A CTRL write that clears en: takes effect for the following cycle; the decrement in the write cycle still occurs.
- Reads of VALUE return the pre-edge value in the pready cycle.
- No arithmetic wraps: the counter never decrements below 0.

Test Plan:
- Reset with presetn=0 for 2 cycles, then read all four registers with WAIT_STATES=1:
  - each read takes 3 cycles (setup, 1 wait, complete);
  - prdata=0 and pslverr=0 throughout.
- Write LOAD=5, then CTRL=0x1:
  - VALUE reads follow 5,4,...,0;
  - INTSTAT[0]=1 one cycle after VALUE reaches 0, and en is cleared;
  - irq stays 0 because irq_en=0.
- Write LOAD=3, then CTRL=0x7:
  - VALUE cycles 3,2,1,0,3,...;
  - irq rises at the first expiry;
  - write INTSTAT=1 and irq drops, then re-asserts at the next expiry.
- Error checks:
  - read paddr=0x20 -> pslverr=1, prdata=0;
  - write VALUE -> pslverr=1 and VALUE is unaffected;
  - read paddr=0x04 -> pslverr=1.
- Rebuild with WAIT_STATES=0 and run back-to-back write/read of LOAD=0xDEAD_BEEF:
  - each transfer takes 2 cycles;
  - the read returns 0x00000000DEADBEEF.
- Collisions and aborts:
  - Force an expiry on the same edge as a W1C write: INTSTAT[0] remains 1.
  - Assert presetn=0 during an access wait state: pready=0 and all registers are 0 on the next cycle.
